// File: rtl/playfield_pkg.sv
// ---------------------------------------------------------------------------
// playfield_pkg
// Shared definitions for the playfield controller:
//   - board geometry (COLS x ROWS)
//   - controller state encodings
//   - line-clear score table and lookup helper
// ---------------------------------------------------------------------------
package playfield_pkg;

   localparam int COLS = 10;
   localparam int ROWS = 12;

   typedef enum logic [2:0] {
      ST_INI   = 3'd0,
      ST_GEN   = 3'd1,
      ST_WAITB = 3'd2,
      ST_LOCK  = 3'd3,
      ST_SCAN  = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   // Points awarded per piece, indexed by the number of rows that piece cleared.
   localparam logic [3:0] SCORE_TAB [5] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd8};

   // A single piece spans at most four rows, so anything beyond four is
   // treated as a four-row clear.
   function automatic logic [3:0] line_points(input logic [2:0] pc);
      logic [3:0] pts;
      if (pc > 3'd4) pts = SCORE_TAB[4];
      else           pts = SCORE_TAB[pc];
      return pts;
   endfunction

endpackage

// File: rtl/playfield_ctrl_edge.sv
// ---------------------------------------------------------------------------
// edge_rise
// Rising-edge detector against a registered copy of the input.
// Ports:
//   Clk   - clock, rising edge
//   Reset - asynchronous active-high reset (clears the history register)
//   d     - level input
//   pulse - high while d is 1 and the registered previous value is 0
// ---------------------------------------------------------------------------
module edge_rise (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic pulse
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = d;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) prev_q <= 1'b0;
      else       prev_q <= prev_d;
   end

   assign pulse = d & ~prev_q;

endmodule

// File: rtl/playfield_ctrl.sv
// ---------------------------------------------------------------------------
// playfield_ctrl
// Falling-block playfield controller. Requests a block, waits for it to land,
// ORs the four landed cells into the board, then scans the board bottom-up one
// row per cycle, collapsing full rows and scoring the piece before requesting
// the next one (or stopping in OVER if the block reached the top row).
// Ports:
//   Clk, Reset           - clock (rising edge), asynchronous active-high reset
//   bottom_flag          - level-high while the generator's block is landed
//   top_flag             - landed block touches row 11
//   Ack                  - player acknowledge, only honoured in OVER
//   x1..x4, y1..y4       - landed cell coordinates (x 0..9, y 0..11)
//   arr0..arr11          - board rows, arrN[i] = cell (i, N) occupied
//   gen_flag             - one-cycle request for the next block
//   game_over            - high while in OVER
//   score                - accumulated score, saturating
//   lines                - total cleared rows, saturating at 255
//   state                - current state encoding
// ---------------------------------------------------------------------------
module playfield_ctrl
   import playfield_pkg::*;
#(
   parameter int SCORE_W = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               bottom_flag,
   input  logic               top_flag,
   input  logic               Ack,
   input  logic [3:0]         x1,
   input  logic [3:0]         x2,
   input  logic [3:0]         x3,
   input  logic [3:0]         x4,
   input  logic [3:0]         y1,
   input  logic [3:0]         y2,
   input  logic [3:0]         y3,
   input  logic [3:0]         y4,
   output logic [9:0]         arr0,
   output logic [9:0]         arr1,
   output logic [9:0]         arr2,
   output logic [9:0]         arr3,
   output logic [9:0]         arr4,
   output logic [9:0]         arr5,
   output logic [9:0]         arr6,
   output logic [9:0]         arr7,
   output logic [9:0]         arr8,
   output logic [9:0]         arr9,
   output logic [9:0]         arr10,
   output logic [9:0]         arr11,
   output logic               gen_flag,
   output logic               game_over,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         lines,
   output logic [2:0]         state
);

   state_t             state_q, state_d;
   logic [COLS-1:0]    rows_q [ROWS];
   logic [COLS-1:0]    rows_d [ROWS];
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]         lines_q, lines_d;
   logic [2:0]         pc_q, pc_d;
   logic [3:0]         r_q, r_d;
   logic               top_l_q, top_l_d;

   logic               bottom_rise;
   logic [3:0]         cell_x [4];
   logic [3:0]         cell_y [4];
   logic [SCORE_W:0]   score_sum;

   assign cell_x[0] = x1;
   assign cell_x[1] = x2;
   assign cell_x[2] = x3;
   assign cell_x[3] = x4;
   assign cell_y[0] = y1;
   assign cell_y[1] = y2;
   assign cell_y[2] = y3;
   assign cell_y[3] = y4;

   // The history register keeps tracking bottom_flag in every state, so a
   // level that stayed high through LOCK/SCAN/GEN cannot fire in WAITB.
   edge_rise u_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (bottom_flag),
      .pulse (bottom_rise)
   );

   // One extra bit on the sum exposes overflow for score saturation.
   assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(line_points(pc_q));

   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      score_d = score_q;
      lines_d = lines_q;
      pc_d    = pc_q;
      r_d     = r_q;
      top_l_d = top_l_q;

      case (state_q)
         ST_INI: begin
            for (int i = 0; i < ROWS; i++) rows_d[i] = '0;
            score_d = '0;
            lines_d = '0;
            state_d = ST_GEN;
         end
         ST_GEN: begin
            pc_d    = '0;
            state_d = ST_WAITB;
         end
         ST_WAITB: begin
            if (bottom_rise) state_d = ST_LOCK;
         end
         ST_LOCK: begin
            // Off-board cells are dropped; duplicates simply re-set a bit.
            for (int k = 0; k < 4; k++) begin
               if (cell_x[k] < 4'(COLS) && cell_y[k] < 4'(ROWS))
                  rows_d[cell_y[k]][cell_x[k]] = 1'b1;
            end
            top_l_d = top_flag;
            r_d     = '0;
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (&rows_q[r_q]) begin
               // Collapse rows above r down by one; r stays put so the row
               // that just dropped into r is examined next cycle.
               for (int i = 0; i < ROWS-1; i++) begin
                  if (4'(i) >= r_q) rows_d[i] = rows_q[i+1];
               end
               rows_d[ROWS-1] = '0;
               pc_d    = pc_q + 3'd1;
               lines_d = (lines_q == 8'hFF) ? lines_q : lines_q + 8'd1;
            end else if (r_q == 4'(ROWS-1)) begin
               score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               state_d = top_l_q ? ST_OVER : ST_GEN;
            end else begin
               r_d = r_q + 4'd1;
            end
         end
         ST_OVER: begin
            if (Ack) state_d = ST_INI;
         end
         default: begin
            state_d = ST_INI;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_INI;
         for (int i = 0; i < ROWS; i++) rows_q[i] <= '0;
         score_q <= '0;
         lines_q <= '0;
         pc_q    <= '0;
         r_q     <= '0;
         top_l_q <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < ROWS; i++) rows_q[i] <= rows_d[i];
         score_q <= score_d;
         lines_q <= lines_d;
         pc_q    <= pc_d;
         r_q     <= r_d;
         top_l_q <= top_l_d;
      end
   end

   assign arr0      = rows_q[0];
   assign arr1      = rows_q[1];
   assign arr2      = rows_q[2];
   assign arr3      = rows_q[3];
   assign arr4      = rows_q[4];
   assign arr5      = rows_q[5];
   assign arr6      = rows_q[6];
   assign arr7      = rows_q[7];
   assign arr8      = rows_q[8];
   assign arr9      = rows_q[9];
   assign arr10     = rows_q[10];
   assign arr11     = rows_q[11];
   assign gen_flag  = (state_q == ST_GEN);
   assign game_over = (state_q == ST_OVER);
   assign score     = score_q;
   assign lines     = lines_q;
   assign state     = state_q;

endmodule

// File: tb/tb_playfield_ctrl.sv
// ---------------------------------------------------------------------------
// tb_playfield_ctrl
// Directed testbench for playfield_ctrl. Each task drives one scenario and
// compares the DUT against hand-computed values.
// ---------------------------------------------------------------------------
module tb_playfield_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        bottom_flag;
   logic        top_flag;
   logic        Ack;
   logic [3:0]  x1, x2, x3, x4, y1, y2, y3, y4;
   logic [9:0]  arr0, arr1, arr2, arr3, arr4, arr5;
   logic [9:0]  arr6, arr7, arr8, arr9, arr10, arr11;
   logic        gen_flag;
   logic        game_over;
   logic [15:0] score;
   logic [7:0]  lines;
   logic [2:0]  state;

   logic [119:0] board;
   int checks = 0;
   int errors = 0;

   assign board = {arr11, arr10, arr9, arr8, arr7, arr6, arr5, arr4, arr3, arr2, arr1, arr0};

   playfield_ctrl #(.SCORE_W(16)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .bottom_flag (bottom_flag),
      .top_flag    (top_flag),
      .Ack         (Ack),
      .x1 (x1), .x2 (x2), .x3 (x3), .x4 (x4),
      .y1 (y1), .y2 (y2), .y3 (y3), .y4 (y4),
      .arr0 (arr0), .arr1 (arr1), .arr2 (arr2), .arr3 (arr3),
      .arr4 (arr4), .arr5 (arr5), .arr6 (arr6), .arr7 (arr7),
      .arr8 (arr8), .arr9 (arr9), .arr10 (arr10), .arr11 (arr11),
      .gen_flag    (gen_flag),
      .game_over   (game_over),
      .score       (score),
      .lines       (lines),
      .state       (state)
   );

   always #5 Clk = ~Clk;

   // Hard stop in case a scenario wedges somewhere unexpected.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] row(input int n);
      return board[n*10 +: 10];
   endfunction

   task automatic reset_dut();
      Reset = 1'b1;
      bottom_flag = 1'b0;
      top_flag = 1'b0;
      Ack = 1'b0;
      {x1, y1, x2, y2, x3, y3, x4, y4} = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
   endtask

   // Present a landed piece and raise bottom_flag, then count cycles until the
   // next gen_flag or OVER. lat counts the cycle in which bottom_flag rose as 1.
   task automatic lock_piece(input logic [3:0] ax, input logic [3:0] ay,
                             input logic [3:0] bx, input logic [3:0] by,
                             input logic [3:0] cx, input logic [3:0] cy,
                             input logic [3:0] dx, input logic [3:0] dy,
                             input logic top, output int lat, output bit saw_gen);
      @(negedge Clk);
      x1 = ax; y1 = ay; x2 = bx; y2 = by;
      x3 = cx; y3 = cy; x4 = dx; y4 = dy;
      top_flag = top;
      bottom_flag = 1'b1;
      lat = 0;
      saw_gen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge Clk);
         #1;
         lat++;
         if (gen_flag) begin
            saw_gen = 1'b1;
            break;
         end
         if (state == 3'd5) break;
      end
      lat = lat + 1;
      checks++;
      if (!(saw_gen || state == 3'd5)) begin
         errors++;
         $display("FAIL lock_timeout: state=%0d gen_flag=%0b after %0d cycles, required GEN or OVER", state, gen_flag, lat);
      end
   endtask

   task automatic release_bottom();
      @(negedge Clk);
      bottom_flag = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bottom_flag = 1'b0;
      top_flag = 1'b0;
      Ack = 1'b0;
      {x1, y1, x2, y2, x3, y3, x4, y4} = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL reset_ini_state: got %0d want 0", state); end
      checks++;
      if (gen_flag !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags: gen=%0b over=%0b want 0 0", gen_flag, game_over); end
      checks++;
      if (board !== '0 || score !== 16'd0 || lines !== 8'd0) begin errors++; $display("FAIL reset_regs: board=%h score=%0d lines=%0d want 0", board, score, lines); end
      @(posedge Clk); #1;
      checks++;
      if (state !== 3'd1 || gen_flag !== 1'b1) begin errors++; $display("FAIL reset_gen: state=%0d gen=%0b want 1 1", state, gen_flag); end
      @(posedge Clk); #1;
      checks++;
      if (state !== 3'd2 || gen_flag !== 1'b0) begin errors++; $display("FAIL reset_waitb: state=%0d gen=%0b want 2 0", state, gen_flag); end
      checks++;
      if (board !== '0) begin errors++; $display("FAIL reset_board: got %h want 0", board); end
   endtask

   task automatic test_line_lock();
      int lat;
      bit g;
      reset_dut();
      lock_piece(4'd4, 4'd0, 4'd5, 4'd0, 4'd6, 4'd0, 4'd7, 4'd0, 1'b0, lat, g);
      checks++;
      if (lat != 15 || !g) begin errors++; $display("FAIL line_lock_latency: got %0d (gen=%0b) want 15", lat, g); end
      checks++;
      if (row(0) !== 10'h0F0) begin errors++; $display("FAIL line_lock_row0: got %h want 0f0", row(0)); end
      checks++;
      if (board[119:10] !== '0) begin errors++; $display("FAIL line_lock_upper: got %h want 0", board[119:10]); end
      checks++;
      if (score !== 16'd0 || lines !== 8'd0) begin errors++; $display("FAIL line_lock_score: score=%0d lines=%0d want 0 0", score, lines); end
      release_bottom();
   endtask

   // Continues from the line-lock board; Ack is held high to show it is ignored.
   task automatic test_out_of_range();
      int lat;
      bit g;
      Ack = 1'b1;
      lock_piece(4'd10, 4'd0, 4'd2, 4'd12, 4'd15, 4'd15, 4'd9, 4'd11, 1'b0, lat, g);
      checks++;
      if (lat != 15 || !g) begin errors++; $display("FAIL oor_latency: got %0d (gen=%0b) want 15", lat, g); end
      checks++;
      if (row(0) !== 10'h0F0 || row(11) !== 10'h200) begin errors++; $display("FAIL oor_rows: row0=%h row11=%h want 0f0 200", row(0), row(11)); end
      checks++;
      if (board[109:10] !== '0) begin errors++; $display("FAIL oor_middle: got %h want 0", board[109:10]); end
      Ack = 1'b0;
      release_bottom();
   endtask

   task automatic test_back_to_back();
      int lat;
      bit g;
      reset_dut();
      lock_piece(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, lat, g);
      // bottom_flag stays high into WAITB: no edge, so no new lock.
      repeat (5) @(posedge Clk);
      #1;
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL b2b_level_hold: state=%0d want 2", state); end
      checks++;
      if (row(0) !== 10'h001) begin errors++; $display("FAIL b2b_dup_cells: row0=%h want 001", row(0)); end
      release_bottom();
      lock_piece(4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 4'd3, 4'd0, 1'b0, lat, g);
      checks++;
      if (lat != 15 || !g) begin errors++; $display("FAIL b2b_latency: got %0d (gen=%0b) want 15", lat, g); end
      checks++;
      if (row(0) !== 10'h00F) begin errors++; $display("FAIL b2b_row0: got %h want 00f", row(0)); end
      release_bottom();
   endtask

   task automatic test_single_clear();
      int lat;
      bit g;
      reset_dut();
      lock_piece(4'd4, 4'd0, 4'd5, 4'd0, 4'd6, 4'd0, 4'd7, 4'd0, 1'b0, lat, g);
      release_bottom();
      lock_piece(4'd8, 4'd0, 4'd9, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 1'b0, lat, g);
      release_bottom();
      checks++;
      if (row(0) !== 10'h3F0 || row(1) !== 10'h001) begin errors++; $display("FAIL single_preload: row0=%h row1=%h want 3f0 001", row(0), row(1)); end
      lock_piece(4'd0, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 1'b0, lat, g);
      checks++;
      if (lat != 16 || !g) begin errors++; $display("FAIL single_latency: got %0d (gen=%0b) want 16", lat, g); end
      checks++;
      if (row(0) !== 10'h001 || row(1) !== 10'h000) begin errors++; $display("FAIL single_rows: row0=%h row1=%h want 001 000", row(0), row(1)); end
      checks++;
      if (lines !== 8'd1 || score !== 16'd1) begin errors++; $display("FAIL single_score: lines=%0d score=%0d want 1 1", lines, score); end
      release_bottom();
   endtask

   // Continues from single-clear (score=1, lines=1), so the reset is visible.
   task automatic test_reset_mid_scan();
      @(negedge Clk);
      x1 = 4'd5; y1 = 4'd5; x2 = 4'd6; y2 = 4'd5;
      x3 = 4'd7; y3 = 4'd5; x4 = 4'd8; y4 = 4'd5;
      top_flag = 1'b0;
      bottom_flag = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      checks++;
      if (state !== 3'd4) begin errors++; $display("FAIL midscan_in_scan: state=%0d want 4", state); end
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || gen_flag !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL midscan_state: state=%0d gen=%0b over=%0b want 0 0 0", state, gen_flag, game_over); end
      checks++;
      if (board !== '0 || score !== 16'd0 || lines !== 8'd0) begin errors++; $display("FAIL midscan_regs: board=%h score=%0d lines=%0d want 0", board, score, lines); end
      @(negedge Clk);
      Reset = 1'b0;
      bottom_flag = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
   endtask

   task automatic test_quad_clear();
      int lat;
      bit g;
      reset_dut();
      for (int x = 1; x < 10; x++) begin
         lock_piece(4'(x), 4'd0, 4'(x), 4'd1, 4'(x), 4'd2, 4'(x), 4'd3, 1'b0, lat, g);
         release_bottom();
      end
      checks++;
      if (board[39:0] !== {4{10'h3FE}} || board[119:40] !== '0) begin errors++; $display("FAIL quad_preload: board=%h want rows0..3=3fe", board); end
      lock_piece(4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 1'b0, lat, g);
      checks++;
      if (lat != 19 || !g) begin errors++; $display("FAIL quad_latency: got %0d (gen=%0b) want 19", lat, g); end
      checks++;
      if (board !== '0) begin errors++; $display("FAIL quad_board: got %h want 0", board); end
      checks++;
      if (score !== 16'd8 || lines !== 8'd4) begin errors++; $display("FAIL quad_score: score=%0d lines=%0d want 8 4", score, lines); end
      release_bottom();
   endtask

   task automatic test_game_over();
      int lat;
      bit g;
      reset_dut();
      lock_piece(4'd0, 4'd11, 4'd1, 4'd11, 4'd2, 4'd11, 4'd3, 4'd11, 1'b1, lat, g);
      checks++;
      if (g || state !== 3'd5 || game_over !== 1'b1) begin errors++; $display("FAIL over_enter: gen_seen=%0b state=%0d over=%0b want 0 5 1", g, state, game_over); end
      checks++;
      if (lat != 15) begin errors++; $display("FAIL over_latency: got %0d want 15", lat); end
      release_bottom();
      // A fresh bottom_flag edge in OVER must do nothing.
      @(negedge Clk);
      bottom_flag = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if (state !== 3'd5 || gen_flag !== 1'b0 || row(11) !== 10'h00F) begin errors++; $display("FAIL over_hold: state=%0d gen=%0b row11=%h want 5 0 00f", state, gen_flag, row(11)); end
      @(negedge Clk);
      bottom_flag = 1'b0;
      Ack = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (state !== 3'd0 || game_over !== 1'b0) begin errors++; $display("FAIL over_ack: state=%0d over=%0b want 0 0", state, game_over); end
      @(negedge Clk);
      Ack = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (gen_flag !== 1'b1 || board !== '0 || score !== 16'd0) begin errors++; $display("FAIL over_restart: gen=%0b board=%h score=%0d want 1 0 0", gen_flag, board, score); end
   endtask

   initial begin
      test_reset();
      test_line_lock();
      test_out_of_range();
      test_back_to_back();
      test_single_clear();
      test_reset_mid_scan();
      test_quad_clear();
      test_game_over();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
